// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between the loader, fetch and data ports.
// Ports: REQ_*/ADDR_*/WDATA_*/WE_D in, ACK_*/RDATA_* out, MEM_* to/from memory, BUSY, GNT_ID.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_SIZE  = 19
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_L,
    input  logic [ADDR_WIDTH-1:0] ADDR_L,
    input  logic [DATA_SIZE-1:0]  WDATA_L,
    output logic                  ACK_L,
    input  logic                  REQ_F,
    input  logic [ADDR_WIDTH-1:0] ADDR_F,
    output logic                  ACK_F,
    output logic [DATA_SIZE-1:0]  RDATA_F,
    input  logic                  REQ_D,
    input  logic                  WE_D,
    input  logic [ADDR_WIDTH-1:0] ADDR_D,
    input  logic [DATA_SIZE-1:0]  WDATA_D,
    output logic                  ACK_D,
    output logic [DATA_SIZE-1:0]  RDATA_D,
    output logic                  MEM_WR_EN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_SIZE-1:0]  MEM_WR_DATA,
    input  logic [DATA_SIZE-1:0]  MEM_OUT,
    output logic                  BUSY,
    output logic [1:0]            GNT_ID
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_L    = 2'b01;
    localparam logic [1:0] G_F    = 2'b10;
    localparam logic [1:0] G_D    = 2'b11;

    state_t                state_q, state_d;
    logic [1:0]            gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0]  wdata_q, wdata_d;
    logic                  ack_l_q, ack_l_d;
    logic                  ack_f_q, ack_f_d;
    logic                  ack_d_q, ack_d_d;
    logic [DATA_SIZE-1:0]  rdata_f_q, rdata_f_d;
    logic [DATA_SIZE-1:0]  rdata_d_q, rdata_d_d;
    logic                  busy_q, busy_d;
    // 1: data port served last, 0: fetch served last
    logic                  rr_d_q, rr_d_d;

    // A requester still showing its ACK has not yet seen it, so it is masked
    logic elig_l, elig_f, elig_d;
    assign elig_l = REQ_L & ~ack_l_q;
    assign elig_f = REQ_F & ~ack_f_q;
    assign elig_d = REQ_D & ~ack_d_q;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        mem_we_d  = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack_l_d   = 1'b0;
        ack_f_d   = 1'b0;
        ack_d_d   = 1'b0;
        rdata_f_d = rdata_f_q;
        rdata_d_d = rdata_d_q;
        busy_d    = busy_q;
        rr_d_d    = rr_d_q;
        unique case (state_q)
            S_IDLE: begin
                if (elig_l) begin
                    gnt_d   = G_L;
                    we_d    = 1'b1;
                    addr_d  = ADDR_L;
                    wdata_d = WDATA_L;
                end else if (elig_f && (!elig_d || rr_d_q)) begin
                    gnt_d   = G_F;
                    we_d    = 1'b0;
                    addr_d  = ADDR_F;
                end else if (elig_d) begin
                    gnt_d   = G_D;
                    we_d    = WE_D;
                    addr_d  = ADDR_D;
                    wdata_d = WDATA_D;
                end
                if (elig_l || elig_f || elig_d) begin
                    mem_we_d = we_d;
                    state_d  = S_ISSUE;
                    busy_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                unique case (gnt_q)
                    G_L: ack_l_d = 1'b1;
                    G_F: begin
                        ack_f_d   = 1'b1;
                        rdata_f_d = MEM_OUT;
                        rr_d_d    = 1'b0;
                    end
                    G_D: begin
                        ack_d_d = 1'b1;
                        if (!we_q) rdata_d_d = MEM_OUT;
                        rr_d_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            gnt_q     <= G_NONE;
            we_q      <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_l_q   <= 1'b0;
            ack_f_q   <= 1'b0;
            ack_d_q   <= 1'b0;
            rdata_f_q <= '0;
            rdata_d_q <= '0;
            busy_q    <= 1'b0;
            rr_d_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack_l_q   <= ack_l_d;
            ack_f_q   <= ack_f_d;
            ack_d_q   <= ack_d_d;
            rdata_f_q <= rdata_f_d;
            rdata_d_q <= rdata_d_d;
            busy_q    <= busy_d;
            rr_d_q    <= rr_d_d;
        end
    end

    assign ACK_L       = ack_l_q;
    assign ACK_F       = ack_f_q;
    assign ACK_D       = ack_d_q;
    assign RDATA_F     = rdata_f_q;
    assign RDATA_D     = rdata_d_q;
    assign MEM_WR_EN   = mem_we_q;
    assign MEM_ADDRESS = addr_q;
    assign MEM_WR_DATA = wdata_q;
    assign BUSY        = busy_q;
    assign GNT_ID      = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
// Outputs are sampled 1 time unit after the rising edge.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_L, REQ_F, REQ_D, WE_D;
    logic [11:0] ADDR_L, ADDR_F, ADDR_D;
    logic [18:0] WDATA_L, WDATA_D;
    logic        ACK_L, ACK_F, ACK_D;
    logic [18:0] RDATA_F, RDATA_D;
    logic        MEM_WR_EN;
    logic [11:0] MEM_ADDRESS;
    logic [18:0] MEM_WR_DATA;
    logic [18:0] MEM_OUT;
    logic        BUSY;
    logic [1:0]  GNT_ID;

    int checks = 0;
    int errors = 0;

    logic [18:0] mem [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [18:0] bd_data;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (MEM_WR_EN) mem[MEM_ADDRESS] <= MEM_WR_DATA;
        MEM_OUT <= mem[MEM_ADDRESS];
    end

    mem_port_arbiter #(.ADDR_WIDTH(12), .DATA_SIZE(19)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_L(REQ_L), .ADDR_L(ADDR_L), .WDATA_L(WDATA_L), .ACK_L(ACK_L),
        .REQ_F(REQ_F), .ADDR_F(ADDR_F), .ACK_F(ACK_F), .RDATA_F(RDATA_F),
        .REQ_D(REQ_D), .WE_D(WE_D), .ADDR_D(ADDR_D), .WDATA_D(WDATA_D),
        .ACK_D(ACK_D), .RDATA_D(RDATA_D),
        .MEM_WR_EN(MEM_WR_EN), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WR_DATA(MEM_WR_DATA), .MEM_OUT(MEM_OUT),
        .BUSY(BUSY), .GNT_ID(GNT_ID)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        REQ_L = 0; REQ_F = 0; REQ_D = 0; WE_D = 0;
        ADDR_L = 0; ADDR_F = 0; ADDR_D = 0;
        WDATA_L = 0; WDATA_D = 0;
        bd_we = 1; bd_addr = 12'h010; bd_data = 19'h1A5C3;
        tick();
        bd_addr = 12'h300; bd_data = 19'h0F0F0;
        tick();
        bd_we = 0;
        // reset state
        chk("rst_wr_en", MEM_WR_EN, 0);
        chk("rst_addr", MEM_ADDRESS, 0);
        chk("rst_wdata", MEM_WR_DATA, 0);
        chk("rst_acks", {ACK_L, ACK_F, ACK_D}, 0);
        chk("rst_rdata_f", RDATA_F, 0);
        chk("rst_rdata_d", RDATA_D, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_gnt", GNT_ID, 0);
        tick();
        RST = 0;
        tick();

        // single fetch
        REQ_F = 1; ADDR_F = 12'h010;
        tick();
        chk("f1_addr", MEM_ADDRESS, 12'h010);
        chk("f1_gnt", GNT_ID, 2'b10);
        chk("f1_busy", BUSY, 1);
        chk("f1_we1", MEM_WR_EN, 0);
        tick();
        chk("f1_we2", MEM_WR_EN, 0);
        chk("f1_noack", ACK_F, 0);
        tick();
        chk("f1_ack", ACK_F, 1);
        chk("f1_rdata", RDATA_F, 19'h1A5C3);
        chk("f1_idle", BUSY, 0);
        REQ_F = 0;
        tick();
        chk("f1_ackdrop", ACK_F, 0);

        // loader write then data read
        REQ_L = 1; ADDR_L = 12'hFFF; WDATA_L = 19'h7FFFF;
        tick();
        chk("l_we", MEM_WR_EN, 1);
        chk("l_addr", MEM_ADDRESS, 12'hFFF);
        chk("l_wdata", MEM_WR_DATA, 19'h7FFFF);
        chk("l_gnt", GNT_ID, 2'b01);
        tick();
        chk("l_we_off", MEM_WR_EN, 0);
        tick();
        chk("l_ack", ACK_L, 1);
        REQ_L = 0;
        REQ_D = 1; WE_D = 0; ADDR_D = 12'hFFF;
        tick();
        chk("d_gnt", GNT_ID, 2'b11);
        chk("l_ackdrop", ACK_L, 0);
        tick();
        tick();
        chk("d_ack", ACK_D, 1);
        chk("d_rdata", RDATA_D, 19'h7FFFF);
        REQ_D = 0;
        tick();

        // F and D contending: strict alternation, F first
        REQ_F = 1; ADDR_F = 12'h010;
        REQ_D = 1; WE_D = 0; ADDR_D = 12'hFFF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt", GNT_ID, (k % 2 == 0) ? 2'b10 : 2'b11);
            chk("rr_busy", BUSY, 1);
            tick();
            tick();
            chk("rr_acks", {ACK_F, ACK_D}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_ackidle", BUSY, 0);
        end
        chk("rr_rdf", RDATA_F, 19'h1A5C3);
        chk("rr_rdd", RDATA_D, 19'h7FFFF);
        REQ_F = 0; REQ_D = 0;
        tick();

        // L, F and D together
        REQ_L = 1; ADDR_L = 12'h200; WDATA_L = 19'h12345;
        REQ_F = 1; ADDR_F = 12'h010;
        REQ_D = 1; WE_D = 0; ADDR_D = 12'h200;
        tick();
        chk("all_gnt_l", GNT_ID, 2'b01);
        tick();
        tick();
        chk("all_ack_l", {ACK_L, ACK_F, ACK_D}, 3'b100);
        REQ_L = 0;
        tick();
        chk("all_gnt_f", GNT_ID, 2'b10);
        tick();
        tick();
        chk("all_ack_f", {ACK_L, ACK_F, ACK_D}, 3'b010);
        chk("all_rdd_keep", RDATA_D, 19'h7FFFF);
        REQ_F = 0;
        tick();
        chk("all_gnt_d", GNT_ID, 2'b11);
        tick();
        tick();
        chk("all_ack_d", {ACK_L, ACK_F, ACK_D}, 3'b001);
        chk("all_rdd", RDATA_D, 19'h12345);
        REQ_D = 0;
        tick();

        // data write, then fetch read of the same word
        REQ_D = 1; WE_D = 1; ADDR_D = 12'h123; WDATA_D = 19'h00ABC;
        tick();
        chk("dw_we", MEM_WR_EN, 1);
        chk("dw_wdata", MEM_WR_DATA, 19'h00ABC);
        tick();
        tick();
        chk("dw_ack", ACK_D, 1);
        chk("dw_rdd_keep", RDATA_D, 19'h12345);
        REQ_D = 0; WE_D = 0;
        REQ_F = 1; ADDR_F = 12'h123;
        tick();
        tick();
        tick();
        chk("dw_f_ack", ACK_F, 1);
        chk("dw_f_rdata", RDATA_F, 19'h00ABC);
        REQ_F = 0;
        tick();

        // reset during ISSUE of a data write
        REQ_D = 1; WE_D = 1; ADDR_D = 12'h300; WDATA_D = 19'h55555;
        tick();
        chk("rw_we", MEM_WR_EN, 1);
        RST = 1;
        #1;
        chk("rw_we_drop", MEM_WR_EN, 0);
        chk("rw_busy", BUSY, 0);
        chk("rw_gnt", GNT_ID, 0);
        REQ_D = 0;
        tick();
        chk("rw_noack", ACK_D, 0);
        tick();
        RST = 0;
        tick();
        chk("rw_mem_keep", mem[12'h300], 19'h0F0F0);
        REQ_D = 1;
        tick();
        chk("rw2_we", MEM_WR_EN, 1);
        tick();
        tick();
        chk("rw2_ack", ACK_D, 1);
        REQ_D = 0; WE_D = 0;
        tick();
        chk("rw2_mem", mem[12'h300], 19'h55555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported `external_memory` instance between three requesters of the 19-bit CPU: the program loader (write-only), instruction fetch (read-only) and data access (read/write). It sits between the PC/IR and register-file datapath and the memory macro, and replaces direct wiring of `WR_EN`/`ADDRESS`/`WR_DATA`/`MEM_OUT`. Loader traffic has absolute priority. Fetch and data share the port round-robin, with one access in flight at a time.

## Interface
- `ADDR_WIDTH`, 12: memory address width.
- `DATA_SIZE`, 19: memory word width.

- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `REQ_L` in 1; `ADDR_L` in ADDR_WIDTH; `WDATA_L` in DATA_SIZE; `ACK_L` out 1: loader write port.
- `REQ_F` in 1; `ADDR_F` in ADDR_WIDTH; `ACK_F` out 1; `RDATA_F` out DATA_SIZE: fetch read port.
- `REQ_D` in 1; `WE_D` in 1; `ADDR_D` in ADDR_WIDTH; `WDATA_D` in DATA_SIZE; `ACK_D` out 1; `RDATA_D` out DATA_SIZE: data port.
- `MEM_WR_EN` out 1; `MEM_ADDRESS` out ADDR_WIDTH; `MEM_WR_DATA` out DATA_SIZE: to memory.
- `MEM_OUT` in DATA_SIZE: memory synchronous read data, valid one cycle after address.
- `BUSY` out 1: high when state is not IDLE.
- `GNT_ID` out 2: winner of the current or last access. 00 none, 01 L, 10 F, 11 D.

## Operation
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE arbitration:
  - Eligible requester: REQ high and its ACK not high this cycle. The ACK mask prevents re-granting a requester that has not yet dropped REQ.
  - L wins if eligible.
  - Otherwise, if F and D are both eligible, the one not served last wins. `rr_last` resets to D, so F wins the first tie.
  - Otherwise the single eligible requester wins.
- On a win: latch winner, address, write flag (L=1, F=0, D=`WE_D`) and write data. Go to ISSUE.
- ISSUE:
  - `MEM_ADDRESS`/`MEM_WR_DATA` driven from the latches.
  - `MEM_WR_EN` = latched write flag, for exactly this one cycle.
  - Go to RESP.
- RESP:
  - Memory output is valid.
  - Go to IDLE. On that edge, pulse the winner's ACK for one cycle.
  - For a read, load `RDATA_F`/`RDATA_D` from `MEM_OUT`.
  - For a write, leave RDATA unchanged.
  - Update `rr_last` only when F or D was served.
- Requester rules:
  - Hold REQ/ADDR/WE/WDATA stable from REQ rise until ACK is seen.
  - Drop REQ or present a new request in the cycle after ACK.
  - Inputs are sampled only in IDLE. Changes during ISSUE/RESP are ignored.
- `RDATA_F`/`RDATA_D` hold their value until the next read for that port completes.
- `GNT_ID` is updated on the grant edge and holds through IDLE.
- Address wrap-around is not applicable. Addresses pass through unmodified. Out-of-range addresses are the requester's responsibility.

## Timing
- Reset (asynchronous, immediate) values:
  - State IDLE.
  - `MEM_WR_EN`=0, `MEM_ADDRESS`=0, `MEM_WR_DATA`=0.
  - All ACK=0, `RDATA_F`=`RDATA_D`=0.
  - `BUSY`=0, `GNT_ID`=00, `rr_last`=D.
- Reset mid-access: the access is aborted and no ACK is issued. A write in ISSUE is suppressed by the immediate `MEM_WR_EN` clear. Requesters re-request after reset releases.
- Latency: REQ sampled in IDLE at cycle n; ISSUE at n+1; RESP at n+2; ACK and RDATA at n+3.
- Throughput: one access per 3 cycles. The IDLE cycle carrying ACK may grant another eligible requester. The ACKed requester is never eligible in that cycle.
- Simultaneous events:
  - L plus F/D: L wins. F/D stay pending.
  - F and D together: strict alternation while both are asserted.
  - L held continuously starves F/D. This is accepted; the loader runs only while the CPU is halted.
- L request during an F/D access: waits until IDLE, with no preemption.

## Test plan
- Reset then single fetch: memory preloaded with 19'h1A5C3 at 12'h010; `REQ_F`=1, `ADDR_F`=12'h010 at cycle 0 -> `MEM_ADDRESS`=12'h010 at cycle 1; `ACK_F`=1 and `RDATA_F`=19'h1A5C3 at cycle 3; `MEM_WR_EN` stays 0.
- Loader write then data read: L writes 19'h7FFFF to 12'hFFF -> `MEM_WR_EN` high exactly one cycle (cycle 1), `ACK_L` at cycle 3. D then reads 12'hFFF -> `RDATA_D`=19'h7FFFF, `ACK_D` 3 cycles after grant.
- F and D held together for 4 accesses: `GNT_ID` sequence 10,11,10,11; each ACK 3 cycles apart; no double grant in ACK cycles.
- L, F and D asserted together: L granted first (`GNT_ID`=01), then F, then D. `RDATA_D` unchanged by the L and F accesses.
- Data write: `WE_D`=1, `WDATA_D`=19'h00ABC, `ADDR_D`=12'h123 -> `ACK_D` pulses at cycle 3; `RDATA_D` keeps its previous value; a later F read of 12'h123 returns 19'h00ABC.
- `RST` asserted during ISSUE of a D write: `MEM_WR_EN` drops immediately; no ACK; `BUSY`=0; memory at that address is unchanged; the same request after reset release completes normally.
